// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sequencer between instruction fetch and EU data
// requests and a dual-port word RAM. Byte-addressed byte/word requests are
// turned into aligned word operations; odd-byte writes become read-modify-
// write sequences.
// Build option: define MEM_ARB_UNALIGNED_EN to split odd-address word
// accesses into two aligned accesses (second one at A+1, wrapping at 2^20).
// Without it, odd word accesses ignore A[0] and complete as one access.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        f_req,
  input  logic [19:0] f_addr,
  output logic        f_ack,
  output logic [15:0] f_rdata,
  input  logic        e_req,
  input  logic        e_we,
  input  logic        e_word,
  input  logic [19:0] e_addr,
  input  logic [15:0] e_wdata,
  output logic        e_ack,
  output logic [15:0] e_rdata,
  output logic        busy,
  output logic        ram_rd_en,
  output logic        ram_rd_we,
  output logic [19:0] ram_rd_addr,
  input  logic [15:0] ram_rd_data,
  output logic        ram_wr_en,
  output logic        ram_wr_we,
  output logic [19:0] ram_wr_addr,
  output logic [15:0] ram_wr_data
);

`ifdef MEM_ARB_UNALIGNED_EN
  localparam logic SPLIT_EN = 1'b1;
`else
  localparam logic SPLIT_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACC0 = 3'd1,
    ACC1 = 3'd2,
    ACC2 = 3'd3,
    DONE = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic        last_eu_q, last_eu_d;   // 1: EU won the last grant
  logic        owner_eu_q, owner_eu_d;
  logic [19:0] addr_q, addr_d;
  logic        we_q, we_d;
  logic        word_q, word_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] data_q, data_d;         // read result / RMW old word
  logic        f_ack_q, f_ack_d;
  logic        e_ack_q, e_ack_d;
  logic [15:0] f_rdata_q, f_rdata_d;
  logic [15:0] e_rdata_q, e_rdata_d;
  logic        busy_q, busy_d;

  logic        grant_eu_s;
  logic        split_s;                // word access split across two words
  logic        rmw_s;                  // write needs a leading read of W(A)
  logic [19:0] addr1_s;
  logic [19:0] addr_w_s;
  logic [19:0] addr1_w_s;
  logic        rd_en_s;
  logic [19:0] rd_addr_s;
  logic        wr_en_s;
  logic        wr_we_s;
  logic [19:0] wr_addr_s;
  logic [15:0] wr_data_s;

  assign grant_eu_s = e_req & (~f_req | ~last_eu_q);
  assign split_s    = SPLIT_EN & word_q & addr_q[0];
  assign rmw_s      = we_q & addr_q[0] & (~word_q | split_s);
  assign addr1_s    = addr_q + 20'd1;
  assign addr_w_s   = {addr_q[19:1], 1'b0};
  assign addr1_w_s  = {addr1_s[19:1], 1'b0};

  // RAM operation decode: exactly one read or write per ACC state
  always_comb begin
    rd_en_s   = 1'b0;
    rd_addr_s = 20'h00000;
    wr_en_s   = 1'b0;
    wr_we_s   = 1'b0;
    wr_addr_s = 20'h00000;
    wr_data_s = 16'h0000;
    case (state_q)
      ACC0: begin
        if (we_q && !rmw_s) begin
          wr_en_s   = 1'b1;
          wr_we_s   = word_q;
          wr_addr_s = addr_w_s;
          wr_data_s = word_q ? wdata_q : {8'h00, wdata_q[7:0]};
        end else begin
          rd_en_s   = 1'b1;
          rd_addr_s = addr_w_s;
        end
      end
      ACC1: begin
        if (we_q) begin
          wr_en_s   = 1'b1;
          wr_we_s   = 1'b1;
          wr_addr_s = addr_w_s;
          wr_data_s = {wdata_q[7:0], data_q[7:0]};
        end else begin
          rd_en_s   = 1'b1;
          rd_addr_s = addr1_w_s;
        end
      end
      ACC2: begin
        wr_en_s   = 1'b1;
        wr_we_s   = 1'b0;
        wr_addr_s = addr1_w_s;
        wr_data_s = {8'h00, wdata_q[15:8]};
      end
      default: begin
        rd_en_s = 1'b0;
        wr_en_s = 1'b0;
      end
    endcase
  end

  // Next-state, request latching, read capture and ack/rdata generation
  always_comb begin
    state_d    = state_q;
    last_eu_d  = last_eu_q;
    owner_eu_d = owner_eu_q;
    addr_d     = addr_q;
    we_d       = we_q;
    word_d     = word_q;
    wdata_d    = wdata_q;
    data_d     = data_q;
    f_ack_d    = 1'b0;
    e_ack_d    = 1'b0;
    f_rdata_d  = 16'h0000;
    e_rdata_d  = 16'h0000;
    case (state_q)
      IDLE: begin
        if (f_req || e_req) begin
          state_d    = ACC0;
          owner_eu_d = grant_eu_s;
          last_eu_d  = grant_eu_s;
          data_d     = 16'h0000;
          if (grant_eu_s) begin
            addr_d  = e_addr;
            we_d    = e_we;
            word_d  = e_word;
            wdata_d = e_wdata;
          end else begin
            addr_d  = f_addr;
            we_d    = 1'b0;
            word_d  = 1'b1;
            wdata_d = 16'h0000;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACC0: begin
        if (we_q) begin
          if (rmw_s) begin
            data_d  = ram_rd_data;
            state_d = ACC1;
          end else begin
            state_d = DONE;
          end
        end else if (split_s) begin
          data_d  = {8'h00, ram_rd_data[15:8]};
          state_d = ACC1;
        end else if (word_q) begin
          data_d  = ram_rd_data;
          state_d = DONE;
        end else begin
          data_d  = {8'h00, (addr_q[0] ? ram_rd_data[15:8] : ram_rd_data[7:0])};
          state_d = DONE;
        end
      end
      ACC1: begin
        if (we_q) begin
          state_d = split_s ? ACC2 : DONE;
        end else begin
          data_d  = {ram_rd_data[7:0], data_q[7:0]};
          state_d = DONE;
        end
      end
      ACC2: begin
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // ack and rdata are registered, so they are loaded on entry to DONE
    if (state_d == DONE) begin
      e_ack_d   = owner_eu_q;
      f_ack_d   = ~owner_eu_q;
      e_rdata_d = (owner_eu_q && !we_q) ? data_d : 16'h0000;
      f_rdata_d = (!owner_eu_q) ? data_d : 16'h0000;
    end else begin
      e_ack_d   = 1'b0;
      f_ack_d   = 1'b0;
      e_rdata_d = 16'h0000;
      f_rdata_d = 16'h0000;
    end
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers; reset drops any transaction in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      last_eu_q  <= 1'b0;
      owner_eu_q <= 1'b0;
      addr_q     <= 20'h00000;
      we_q       <= 1'b0;
      word_q     <= 1'b0;
      wdata_q    <= 16'h0000;
      data_q     <= 16'h0000;
      f_ack_q    <= 1'b0;
      e_ack_q    <= 1'b0;
      f_rdata_q  <= 16'h0000;
      e_rdata_q  <= 16'h0000;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_eu_q  <= last_eu_d;
      owner_eu_q <= owner_eu_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      word_q     <= word_d;
      wdata_q    <= wdata_d;
      data_q     <= data_d;
      f_ack_q    <= f_ack_d;
      e_ack_q    <= e_ack_d;
      f_rdata_q  <= f_rdata_d;
      e_rdata_q  <= e_rdata_d;
      busy_q     <= busy_d;
    end
  end

  assign f_ack       = f_ack_q;
  assign f_rdata     = f_rdata_q;
  assign e_ack       = e_ack_q;
  assign e_rdata     = e_rdata_q;
  assign busy        = busy_q;
  assign ram_rd_en   = rd_en_s;
  assign ram_rd_we   = rd_en_s;
  assign ram_rd_addr = rd_addr_s;
  // no RAM write may land in a reset cycle, even mid-sequence
  assign ram_wr_en   = wr_en_s & ~rst;
  assign ram_wr_we   = wr_we_s;
  assign ram_wr_addr = wr_addr_s;
  assign ram_wr_data = wr_data_s;

endmodule
